// File: rtl/udp_pixel_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module  : udp_pixel_unpacker_if
// Brief   : UDP payload byte stream in, tagged pixel stream out (valid/ready).
// Revision: 1.0
// ============================================================================
interface udp_pixel_unpacker_if #(
    parameter int NUM_CH = 3,
    parameter int X_W    = 11,
    parameter int Y_W    = 11
);
    logic                udp_rx_valid;
    logic                udp_rx_last;
    logic [7:0]          udp_rx_data;
    logic [8*NUM_CH-1:0] pixel;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic                sol;
    logic                valid;
    logic                ready;

    modport master (
        input  udp_rx_valid, udp_rx_last, udp_rx_data, ready,
        output pixel, x, y, sol, valid
    );

    modport slave (
        output udp_rx_valid, udp_rx_last, udp_rx_data, ready,
        input  pixel, x, y, sol, valid
    );
endinterface
`default_nettype wire

// File: rtl/udp_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module  : udp_pixel_unpacker
// Brief   : Strips a 2-byte row header and packs UDP bytes into tagged pixels.
// Revision: 1.0
// ============================================================================
module udp_pixel_unpacker #(
    parameter int NUM_CH     = 3,
    parameter int X_W        = 11,
    parameter int Y_W        = 11,
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic        i_msb_first,
    input  wire logic        i_clr_stat,
    udp_pixel_unpacker_if.master pix_if,
    output logic [15:0]      o_pkt_cnt,
    output logic [7:0]       o_short_cnt,
    output logic             o_ovf
);

    localparam int PIX_W = 8 * NUM_CH;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int E_W   = PIX_W + X_W + Y_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_HDR0 = 2'd1,
        S_HDR1 = 2'd2,
        S_PIX  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         y_hi_q, y_hi_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sol_pend_q, sol_pend_d;
    logic [PIX_W-1:0]   pix_q, pix_d;

    logic [PIX_W-1:0]   pix_full;
    logic [IDX_W-1:0]   slot;
    logic [15:0]        hdr;
    logic               push_req, pkt_inc, short_inc;

    logic [E_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fifo_full, fifo_pop, push_ok, push_drop;
    logic [E_W-1:0]     head;

    assign hdr = {y_hi_q, pix_if.udp_rx_data};

    // Channel slot for the incoming byte; reversed order when MSB-first.
    always_comb begin
        slot     = i_msb_first ? (LAST_IDX - idx_q) : idx_q;
        pix_full = pix_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (IDX_W'(c) == slot) begin
                pix_full[8*c +: 8] = pix_if.udp_rx_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        y_hi_d     = y_hi_q;
        y_d        = y_q;
        x_d        = x_q;
        idx_d      = idx_q;
        sol_pend_d = sol_pend_q;
        pix_d      = pix_q;
        push_req   = 1'b0;
        pkt_inc    = 1'b0;
        short_inc  = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (!pix_if.udp_rx_valid || pix_if.udp_rx_last) begin
                    state_d = S_HDR0;
                end
            end
            S_HDR0: begin
                if (pix_if.udp_rx_valid) begin
                    y_hi_d = pix_if.udp_rx_data;
                    if (pix_if.udp_rx_last) begin
                        short_inc = 1'b1;
                    end else begin
                        state_d = S_HDR1;
                    end
                end
            end
            S_HDR1: begin
                if (pix_if.udp_rx_valid) begin
                    y_d        = hdr[Y_W-1:0];
                    x_d        = '0;
                    idx_d      = '0;
                    sol_pend_d = 1'b1;
                    if (pix_if.udp_rx_last) begin
                        short_inc = 1'b1;
                        state_d   = S_HDR0;
                    end else begin
                        state_d = S_PIX;
                    end
                end
            end
            S_PIX: begin
                if (pix_if.udp_rx_valid) begin
                    pix_d = pix_full;
                    if (idx_q == LAST_IDX) begin
                        push_req   = 1'b1;
                        x_d        = x_q + X_W'(1);
                        sol_pend_d = 1'b0;
                        idx_d      = '0;
                        if (pix_if.udp_rx_last) begin
                            pkt_inc = 1'b1;
                            state_d = S_HDR0;
                        end
                    end else if (pix_if.udp_rx_last) begin
                        short_inc = 1'b1;
                        idx_d     = '0;
                        state_d   = S_HDR0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            y_hi_q     <= '0;
            y_q        <= '0;
            x_q        <= '0;
            idx_q      <= '0;
            sol_pend_q <= 1'b0;
            pix_q      <= '0;
        end else begin
            y_hi_q     <= y_hi_d;
            y_q        <= y_d;
            x_q        <= x_d;
            idx_q      <= idx_d;
            sol_pend_q <= sol_pend_d;
            pix_q      <= pix_d;
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_pop  = pix_if.valid && pix_if.ready;
    assign push_ok   = push_req && (!fifo_full || fifo_pop);
    assign push_drop = push_req && !push_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {pix_full, x_q, y_q, sol_pend_q};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, fifo_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign pix_if.pixel = head[E_W-1 -: PIX_W];
    assign pix_if.x     = head[Y_W+1 +: X_W];
    assign pix_if.y     = head[1 +: Y_W];
    assign pix_if.sol   = head[0];
    assign pix_if.valid = (cnt_q != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pkt_cnt   <= '0;
            o_short_cnt <= '0;
            o_ovf       <= 1'b0;
        end else if (i_clr_stat) begin
            o_pkt_cnt   <= '0;
            o_short_cnt <= '0;
            o_ovf       <= 1'b0;
        end else begin
            if (pkt_inc) begin
                o_pkt_cnt <= o_pkt_cnt + 16'd1;
            end
            if (short_inc && (o_short_cnt != 8'hFF)) begin
                o_short_cnt <= o_short_cnt + 8'd1;
            end
            if (push_drop) begin
                o_ovf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module  : tb_udp_pixel_unpacker
// Brief   : Vector table plus directed corner sequences for udp_pixel_unpacker.
// Revision: 1.0
// ============================================================================
module tb_udp_pixel_unpacker;

    typedef logic [46:0] ent_t;   // {pixel[23:0], x[10:0], y[10:0], sol}

    typedef struct {
        int          n;
        logic [63:0] bytes;   // first byte in [63:56]
        logic        msb;
        int          npix;
        logic [47:0] pix;     // first pixel in [47:24]
        logic [10:0] y;
        int          dpkt;
        int          dshort;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        msb_first;
    logic        clr_stat;
    logic [15:0] pkt_cnt;
    logic [7:0]  short_cnt;
    logic        ovf;

    int   checks = 0;
    int   errors = 0;
    ent_t got_q[$];
    vec_t vec[7];

    udp_pixel_unpacker_if #(.NUM_CH(3), .X_W(11), .Y_W(11)) bus ();

    udp_pixel_unpacker #(
        .NUM_CH(3), .X_W(11), .Y_W(11), .FIFO_DEPTH(8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_msb_first (msb_first),
        .i_clr_stat  (clr_stat),
        .pix_if      (bus.master),
        .o_pkt_cnt   (pkt_cnt),
        .o_short_cnt (short_cnt),
        .o_ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.valid && bus.ready) begin
            got_q.push_back({bus.pixel, bus.x, bus.y, bus.sol});
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        bus.udp_rx_valid = 1'b1;
        bus.udp_rx_data  = b;
        bus.udp_rx_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.udp_rx_valid = 1'b0;
        bus.udp_rx_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ent(input string name, input ent_t e, input logic [23:0] pix,
                           input int x, input logic [10:0] y, input logic sol);
        chk({name, "_pixel"}, 128'(e[46:23]), 128'(pix));
        chk({name, "_x"},     128'(e[22:12]), 128'(11'(x)));
        chk({name, "_y"},     128'(e[11:1]),  128'(y));
        chk({name, "_sol"},   128'(e[0]),     128'(sol));
    endtask

    initial begin
        int exp_pkt;
        int exp_short;
        logic [23:0] ep;

        vec[0] = '{8, 64'h0005102030405060, 1'b1, 2, 48'h102030405060, 11'd5,     1, 0};
        vec[1] = '{8, 64'h0005102030405060, 1'b0, 2, 48'h302010605040, 11'd5,     1, 0};
        vec[2] = '{6, 64'h0001AABBCCDD0000, 1'b1, 1, 48'hAABBCC000000, 11'd1,     0, 1};
        vec[3] = '{5, 64'h0007010203000000, 1'b1, 1, 48'h010203000000, 11'd7,     1, 0};
        vec[4] = '{1, 64'h0000000000000000, 1'b1, 0, 48'h0,           11'd0,     0, 1};
        vec[5] = '{2, 64'h0009000000000000, 1'b1, 0, 48'h0,           11'd0,     0, 1};
        vec[6] = '{5, 64'h12340A0B0C000000, 1'b1, 1, 48'h0A0B0C000000, 11'h234,  1, 0};

        rst_n            = 1'b0;
        msb_first        = 1'b1;
        clr_stat         = 1'b0;
        bus.ready        = 1'b1;
        bus.udp_rx_valid = 1'b0;
        bus.udp_rx_last  = 1'b0;
        bus.udp_rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_outputs",
            128'({bus.valid, bus.pixel, bus.x, bus.y, bus.sol, pkt_cnt, short_cnt, ovf}), 128'(0));
        idle(2);

        exp_pkt   = 0;
        exp_short = 0;
        for (int v = 0; v < 7; v++) begin
            got_q.delete();
            msb_first = vec[v].msb;
            for (int i = 0; i < vec[v].n; i++) begin
                send(vec[v].bytes[63-8*i -: 8], (i == vec[v].n - 1));
            end
            idle(4);
            exp_pkt   += vec[v].dpkt;
            exp_short += vec[v].dshort;
            chk($sformatf("v%0d_npix", v), 128'(got_q.size()), 128'(vec[v].npix));
            for (int k = 0; k < vec[v].npix && k < got_q.size(); k++) begin
                chk_ent($sformatf("v%0d_p%0d", v, k), got_q[k],
                        vec[v].pix[47-24*k -: 24], k, vec[v].y, (k == 0));
            end
            chk($sformatf("v%0d_pkt_cnt", v),   128'(pkt_cnt),   128'(exp_pkt));
            chk($sformatf("v%0d_short_cnt", v), 128'(short_cnt), 128'(exp_short));
        end

        // Clear coinciding with the packet-complete increment: clear wins.
        msb_first = 1'b1;
        got_q.delete();
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        clr_stat = 1'b1;
        send(8'h03, 1'b1);
        clr_stat = 1'b0;
        idle(3);
        chk("clr_wins_pkt",   128'(pkt_cnt),   128'(0));
        chk("clr_wins_short", 128'(short_cnt), 128'(0));
        chk("clr_wins_npix",  128'(got_q.size()), 128'(1));

        // Runt stream to saturate the short counter.
        for (int i = 0; i < 254; i++) send(8'h00, 1'b1);
        idle(1);
        chk("short_254", 128'(short_cnt), 128'(254));
        for (int i = 0; i < 6; i++) send(8'h00, 1'b1);
        idle(1);
        chk("short_sat", 128'(short_cnt), 128'(255));

        // Stalled consumer: 10 pixels into an 8-deep FIFO.
        bus.ready = 1'b0;
        got_q.delete();
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 3; c++) begin
                send(8'(3*p + c + 1), (p == 9 && c == 2));
                if (p == 0 && c == 1) chk("lat_before", 128'(bus.valid), 128'(0));
                if (p == 0 && c == 2) chk("lat_after",  128'(bus.valid), 128'(1));
            end
        end
        idle(2);
        chk("stall_ovf",    128'(ovf),       128'(1));
        chk("stall_head_x", 128'(bus.x),     128'(0));
        chk("stall_pkt",    128'(pkt_cnt),   128'(1));
        idle(3);
        chk("stall_hold", 128'({bus.valid, bus.pixel, bus.sol}), 128'({1'b1, 24'h010203, 1'b1}));
        chk("stall_no_pop", 128'(got_q.size()), 128'(0));
        bus.ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_count", 128'(got_q.size()), 128'(8));
        chk("drain_empty", 128'(bus.valid),    128'(0));
        for (int k = 0; k < 8 && k < got_q.size(); k++) begin
            ep = {8'(3*k + 1), 8'(3*k + 2), 8'(3*k + 3)};
            chk_ent($sformatf("drain%0d", k), got_q[k], ep, k, 11'd2, (k == 0));
        end
        clr_stat = 1'b1;
        @(posedge clk);
        #1;
        clr_stat = 1'b0;
        chk("clr_ovf",   128'(ovf),       128'(0));
        chk("clr_short", 128'(short_cnt), 128'(0));
        chk("clr_pkt",   128'(pkt_cnt),   128'(0));

        // Reset asserted mid-packet and released while bytes keep streaming.
        send(8'h00, 1'b0);
        send(8'h04, 1'b0);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hB1, 1'b0);
        rst_n = 1'b0;
        send(8'hB2, 1'b0);
        rst_n = 1'b1;
        got_q.delete();
        chk("rst_mid_valid", 128'(bus.valid), 128'(0));
        send(8'hB3, 1'b0);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        send(8'hE3, 1'b1);
        idle(3);
        chk("rst_no_pix", 128'(got_q.size()), 128'(0));
        chk("rst_no_pkt", 128'(pkt_cnt),      128'(0));
        send(8'h00, 1'b0);
        send(8'h0C, 1'b0);
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        send(8'hD3, 1'b1);
        idle(4);
        chk("resync_npix", 128'(got_q.size()), 128'(1));
        if (got_q.size() > 0) begin
            chk_ent("resync", got_q[0], 24'hD1D2D3, 0, 11'd12, 1'b1);
        end
        chk("resync_pkt", 128'(pkt_cnt), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/udp_pixel_unpacker.md
Name: udp_pixel_unpacker

Overview:
- Parametrised successor to the fixed 3-byte RGB24 UDP parser.
- Unpacks UDP payload bytes into NUM_CH-byte pixels and strips a 2-byte big-endian row header per packet.
- Tags each pixel with x/y coordinates and start-of-line, and buffers pixels in a FWFT FIFO with valid/ready so a downstream dehaze pipeline can stall.
- Sits between the Ethernet UDP RX core, which cannot be back-pressured, and the pixel-stream consumer.

Parameters:
- NUM_CH, 3, bytes (channels) per pixel; legal range 1..4.
- X_W, 11, width of the o_x pixel column counter.
- Y_W, 11, width of o_y; taken from the low Y_W bits of the 16-bit header.
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_udp_rx_valid  in  1  payload byte valid
- i_udp_rx_last  in  1  last payload byte of packet; qualified by valid
- i_udp_rx_data  in  8  payload byte
- i_msb_first  in  1  1: first byte of a pixel goes to o_pixel[8*NUM_CH-1 -: 8] (BGR-style); 0: first byte goes to o_pixel[7:0]
- i_clr_stat  in  1  synchronous clear of statistics and o_ovf
- o_pixel  out  8*NUM_CH  assembled pixel
- o_x  out  X_W  pixel column within packet, starting at 0
- o_y  out  Y_W  row from packet header
- o_sol  out  1  first pixel of a packet
- o_valid  out  1  FIFO head valid
- i_ready  in  1  consumer accepts head when o_valid && i_ready
- o_pkt_cnt  out  16  complete packets parsed; wraps
- o_short_cnt  out  8  runt packets or packets with a trailing partial pixel; saturates at 255
- o_ovf  out  1  sticky: at least one pixel dropped because the FIFO was full

Behaviour:
- Reset is asynchronous and active-low on i_rst_n; clock is i_clk.
- Reset values: all outputs 0, FIFO empty, state S_SYNC, byte index 0, x 0.
- Input bytes are examined only when i_udp_rx_valid=1.
- State machine:
  - S_SYNC: discard bytes. Go to S_HDR0 on any cycle with valid=0, or on valid&&last. This resyncs after a reset released mid-packet.
  - S_HDR0: on a byte, latch y_hi. If last: short_cnt++, stay in S_HDR0. Else go to S_HDR1.
  - S_HDR1: on a byte, latch y_lo, clear x and byte index, set sol_pending. If last: short_cnt++, go to S_HDR0. Else go to S_PIX.
  - S_PIX: place each byte into channel slot per i_msb_first, with i_msb_first sampled per byte; byte index counts 0..NUM_CH-1.
    - When index=NUM_CH-1: push {pixel, x, y, sol_pending}, x++ (wraps at X_W), clear sol_pending, index back to 0.
    - On last with index=NUM_CH-1: push the pixel, pkt_cnt++, go to S_HDR0.
    - On last with any other index: discard the partial pixel, short_cnt++, go to S_HDR0. No pkt_cnt increment.
- FIFO:
  - A push is accepted if the FIFO is not full, or a pop occurs in the same cycle.
  - Otherwise the pixel is dropped and o_ovf is set. x still advances and sol_pending still clears.
  - Latency: the last byte of a pixel on cycle N gives o_valid=1 on cycle N+1 with the FIFO previously empty.
  - o_pixel, o_x, o_y, o_sol show the head entry and are held stable while o_valid && !i_ready.
  - Push and pop on an empty FIFO: the push is stored, and o_valid follows the push timing.
- Statistics:
  - If i_clr_stat coincides with an increment or an overflow, the clear wins.
  - o_pkt_cnt wraps at 65535 to 0.
  - o_short_cnt holds at 255.
- NUM_CH=1: every S_PIX byte is one pixel. i_msb_first has no effect.

Test Plan:
- NUM_CH=3, i_msb_first=1, i_ready=1. Packet 00 05 10 20 30 40 50 60, last on 0x60. Two pixels: 0x102030 (x=0, y=5, sol=1), then 0x405060 (x=1, sol=0). Then o_pkt_cnt=1, o_short_cnt=0.
- Same packet with i_msb_first=0: pixels 0x302010 and 0x605040.
- Packet 00 01 AA BB CC DD, last on 0xDD. One pixel 0xAABBCC. 0xDD discarded. o_short_cnt=1, o_pkt_cnt=0. The next packet parses normally with sol=1.
- Runt packet 00, last on 0x00: short_cnt=1, no output. A header-only packet also gives short_cnt+1.
- i_ready=0, FIFO_DEPTH=8, 10-pixel packet: first 8 pixels held with x=0..7. Pixels x=8,9 dropped and o_ovf=1. Raising i_ready drains x=0..7 in order, one per cycle. Pulsing i_clr_stat clears o_ovf.
- Assert reset mid-packet, release while bytes are still streaming: no pixel output until the next packet. The next packet's header is parsed correctly with y matching the header.
